// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the data memory unit and its store buffer
package mem_pkg;

  localparam int DEF_N        = 24;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_SB_DEPTH = 4;
  localparam int DEF_WR_LAT   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] index;
    logic [DEF_N-1:0]      data;
  } store_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - store buffer FIFO with youngest-match load forwarding
module store_buffer_fifo
  import mem_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_SB_DEPTH,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_index,
  input  logic [N-1:0]      push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_index,
  output logic [ADDR_W-1:0] head_index,
  output logic [N-1:0]      head_data,
  output logic [CW-1:0]     count,
  output logic              hit,
  output logic [N-1:0]      hit_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] index;
    logic [N-1:0]      data;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Physical slot of the entry that is 'age' positions behind the head.
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] h, input int age);
    int s;
    s = int'(h) + age;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{index: push_index, data: push_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= bump(tail);
      if (pop)  head <= bump(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_index = entries[head].index;
  assign head_data  = entries[head].data;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count)) begin
        if (entries[slot_of(head, k)].index == lookup_index) begin
          hit      = 1'b1;
          hit_data = entries[slot_of(head, k)].data;
        end
      end
    end
  end

endmodule

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - data RAM fronted by a store buffer with a fixed-latency drain FSM
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  parameter int WR_LAT   = DEF_WR_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          MemWrite,
  input  logic [N-1:0]                  Addr,
  input  logic [N-1:0]                  WriteData,
  output logic [N-1:0]                  ReadData,
  output logic                          StallM,
  output logic                          Empty,
  output logic [$clog2(SB_DEPTH+1)-1:0] Count
);

  localparam int CW   = $clog2(SB_DEPTH + 1);
  localparam int CNTW = $clog2(WR_LAT + 1);

  logic [N-1:0]      ram [2**ADDR_W];
  logic [ADDR_W-1:0] index;
  logic              unused_addr_hi;
  logic              full;
  logic              push;
  logic              drain_fire;
  logic [ADDR_W-1:0] head_index;
  logic [N-1:0]      head_data;
  logic              sb_hit;
  logic [N-1:0]      sb_hit_data;
  drain_state_t      state;
  logic [CNTW-1:0]   cnt;

  assign index          = Addr[ADDR_W-1:0];
  assign unused_addr_hi = ^Addr[N-1:ADDR_W];

  // Fullness is judged on the pre-edge count, so a same-cycle pop never admits a stalled store.
  assign full       = (Count == CW'(SB_DEPTH));
  assign push       = MemWrite & en & rst & ~full;
  assign drain_fire = rst & (state == BUSY) & (cnt == '0);

  store_buffer_fifo #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .DEPTH  (SB_DEPTH),
    .CW     (CW)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_index   (index),
    .push_data    (WriteData),
    .pop          (drain_fire),
    .lookup_index (index),
    .head_index   (head_index),
    .head_data    (head_data),
    .count        (Count),
    .hit          (sb_hit),
    .hit_data     (sb_hit_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Count != '0) begin
            state <= BUSY;
            cnt   <= CNTW'(WR_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if ((Count > CW'(1)) || push) begin
            cnt <= CNTW'(WR_LAT - 1);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // RAM is deliberately outside reset; an aborted drain simply never fires.
  always_ff @(posedge clk) begin
    if (drain_fire) ram[head_index] <= head_data;
  end

  assign ReadData = sb_hit ? sb_hit_data : ram[index];
  assign StallM   = MemWrite & en & full;
  assign Empty    = (Count == '0);

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - scoreboard bench for data_memory_unit against a queue-based model
module tb_data_memory_unit;

  localparam int N     = 24;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int WL    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          MemWrite;
  logic [N-1:0]  Addr;
  logic [N-1:0]  WriteData;
  logic [N-1:0]  ReadData;
  logic          StallM;
  logic          Empty;
  logic [CW-1:0] Count;

  data_memory_unit #(
    .N        (N),
    .ADDR_W   (AW),
    .SB_DEPTH (DEPTH),
    .WR_LAT   (WL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .StallM    (StallM),
    .Empty     (Empty),
    .Count     (Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] idx;
    logic [N-1:0]  data;
  } sb_t;

  typedef struct {
    string        tag;
    logic [N-1:0] rd;
    bit           rd_known;
    bit           stall;
    int           count;
    bit           empty;
  } exp_t;

  sb_t          sb_q  [$];
  logic [N-1:0] ram_m [int];
  exp_t         exp_q [$];
  exp_t         mx;
  int           edge_n = 0;
  int           due    = -1;
  int           errors = 0;
  int           checks = 0;

  function automatic exp_t predict(input bit w, input bit e, input logic [N-1:0] a, input string tag);
    exp_t          x;
    logic [AW-1:0] idx;
    idx        = a[AW-1:0];
    x.tag      = tag;
    x.rd       = '0;
    x.rd_known = 1'b0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!x.rd_known && sb_q[i].idx == idx) begin
        x.rd       = sb_q[i].data;
        x.rd_known = 1'b1;
      end
    end
    if (!x.rd_known && ram_m.exists(int'(idx))) begin
      x.rd       = ram_m[int'(idx)];
      x.rd_known = 1'b1;
    end
    x.stall = w && e && (sb_q.size() == DEPTH);
    x.count = sb_q.size();
    x.empty = (sb_q.size() == 0);
    return x;
  endfunction

  // The head store retires on edge 'due'; an idle buffer schedules its first write WL edges after it is seen non-empty.
  task automatic model_edge(input bit r, input bit w, input bit e, input logic [N-1:0] a, input logic [N-1:0] d);
    bit  push;
    sb_t s;
    edge_n++;
    if (!r) begin
      sb_q.delete();
      due = -1;
      return;
    end
    push = w && e && (sb_q.size() < DEPTH);
    if (due == edge_n) begin
      ram_m[int'(sb_q[0].idx)] = sb_q[0].data;
      void'(sb_q.pop_front());
      due = (sb_q.size() > 0 || push) ? edge_n + WL : -1;
    end else if (due < 0 && sb_q.size() > 0) begin
      due = edge_n + WL;
    end
    if (push) begin
      s.idx  = a[AW-1:0];
      s.data = d;
      sb_q.push_back(s);
    end
  endtask

  task automatic cycle(input bit r, input bit w, input bit e, input logic [N-1:0] a,
                       input logic [N-1:0] d, input string tag);
    rst       = r;
    MemWrite  = w;
    en        = e;
    Addr      = a;
    WriteData = d;
    exp_q.push_back(predict(w, e, a, tag));
    @(posedge clk);
    model_edge(r, w, e, a, d);
    #1;
  endtask

  function automatic logic [N-1:0] rnd_addr(input int idx);
    logic [N-1:0] a;
    a         = N'($urandom);
    a[AW-1:0] = AW'(idx);
    return a;
  endfunction

  task automatic store_hold(input logic [N-1:0] a, input logic [N-1:0] d, input string tag);
    int tries;
    bit st;
    tries = 0;
    do begin
      st = (sb_q.size() == DEPTH);
      cycle(1'b1, 1'b1, 1'b1, a, d, tag);
      tries++;
    end while (st && tries < 32);
    if (st) begin
      checks++;
      errors++;
      $display("FAIL store_hold [%s]: store still stalled after %0d cycles, required acceptance", tag, tries);
    end
  endtask

  task automatic idle(input int n, input int idx, input string tag);
    repeat (n) cycle(1'b1, 1'b0, 1'b1, rnd_addr(idx), N'($urandom), tag);
  endtask

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s [%s]: got %0h required %0h", name, tag, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mx = exp_q.pop_front();
        if (mx.rd_known) chk("ReadData", mx.tag, 32'(ReadData), 32'(mx.rd));
        chk("StallM", mx.tag, 32'(StallM), 32'(mx.stall));
        chk("Count",  mx.tag, 32'(Count),  32'(mx.count));
        chk("Empty",  mx.tag, 32'(Empty),  32'(mx.empty));
      end
    end
  end

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    MemWrite  = 1'b0;
    Addr      = '0;
    WriteData = '0;
    repeat (2) @(posedge clk);
    #1;

    repeat (3) cycle(1'b0, 1'b1, 1'b1, rnd_addr(1), 24'h123456, "reset");

    for (int i = 0; i < 16; i++) begin
      store_hold(rnd_addr(i), N'($urandom), "preload");
      idle(3, i, "preload_rd");
    end
    idle(6, 0, "settle");

    store_hold(24'h000005, 24'h00ABCD, "fwd_single");
    idle(5, 5, "fwd_single_rd");

    store_hold(24'h000007, 24'h000011, "youngest_a");
    store_hold(24'h000007, 24'h000022, "youngest_b");
    idle(8, 7, "youngest_rd");

    store_hold(24'h800003, 24'h0C0FFE, "hi_bits");
    idle(2, 3, "hi_bits_rd");
    cycle(1'b1, 1'b0, 1'b1, 24'h000003, '0, "hi_bits_rd_lo");
    idle(5, 3, "hi_bits_drain");

    for (int i = 0; i < 7; i++) store_hold(rnd_addr(8 + i), N'($urandom), "burst");
    idle(14, 9, "burst_drain");

    for (int i = 0; i < 3; i++) store_hold(rnd_addr(10 + i), N'($urandom), "en_pre");
    repeat (8) cycle(1'b1, 1'b1, 1'b0, rnd_addr(11), N'($urandom), "en_low");
    idle(4, 12, "en_low_drain");

    store_hold(24'h000009, 24'h5A5A5A, "abort_st");
    idle(2, 9, "abort_wait");
    cycle(1'b0, 1'b0, 1'b1, 24'h000009, '0, "abort_rst");
    idle(4, 9, "abort_rd");

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 63) != 0, 1'($urandom), $urandom_range(0, 9) != 0,
            rnd_addr($urandom_range(0, 15)), N'($urandom), "random");
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 The block SHALL have parameter N, default 24, the data/address word width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, the word-index width (RAM depth 2^ADDR_W).
REQ-003 The block SHALL have parameter SB_DEPTH, default 4, the store-buffer entry count.
REQ-004 The block SHALL have parameter WR_LAT, default 2, cycles per backing-RAM write (>=1).
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 en  input  1  store-accept enable; when low no store is enqueued, while draining continues.
REQ-008 MemWrite  input  1  store request from the Memory stage.
REQ-009 Addr  input  N  Memory-stage ALU result; word index = Addr[ADDR_W-1:0], upper bits ignored.
REQ-010 WriteData  input  N  store data.
REQ-011 ReadData  output  N  load data, combinational from Addr in the same cycle.
REQ-012 StallM  output  1  high when a store is presented while the buffer is full.
REQ-013 Empty  output  1  store buffer holds no entries.
REQ-014 Count  output  $clog2(SB_DEPTH+1)  current store-buffer occupancy.

Function
REQ-015 A store (MemWrite & en & rst) SHALL be enqueued at the clock edge when Count < SB_DEPTH, with entry {index, WriteData}.
REQ-016 StallM SHALL equal MemWrite & en & (Count == SB_DEPTH); a stalled store SHALL NOT be enqueued, and an entry freed in the same cycle SHALL NOT admit it.
REQ-017 The drain FSM SHALL have states IDLE and BUSY plus a down-counter of width $clog2(WR_LAT+1).
REQ-018 IDLE: if Count > 0 at the edge -> BUSY with counter = WR_LAT-1; else remain IDLE.
REQ-019 BUSY, counter > 0: decrement the counter each edge.
REQ-020 BUSY, counter == 0: at that edge RAM[head.index] <= head.data, the head is popped, and the FSM goes to BUSY with counter reload if (Count-1 + enqueue) > 0, else to IDLE.
REQ-021 Simultaneous enqueue and pop SHALL leave Count unchanged and advance both pointers.
REQ-022 Pointers SHALL wrap modulo SB_DEPTH.
REQ-023 A store is written to RAM WR_LAT+1 edges after its enqueue edge when the buffer was otherwise empty and the FSM was IDLE.
REQ-024 ReadData SHALL return the data of the youngest buffer entry whose index matches, including the head currently being written; otherwise it SHALL return RAM[index].
REQ-025 ReadData SHALL be defined on every cycle, irrespective of MemWrite.
REQ-026 The block SHALL perform no arithmetic on data; index compares SHALL use ADDR_W bits only.

Reset
REQ-027 While rst is low at an edge, the block SHALL set Count=0, head and tail pointers to 0, FSM to IDLE, and counter to 0, and SHALL enqueue nothing.
REQ-028 A write whose completion edge coincides with rst low SHALL be aborted; RAM SHALL NOT be modified and buffered stores SHALL be discarded.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Output values after reset SHALL be Empty=1, Count=0, StallM=0, and ReadData=RAM[index].

Structure
REQ-031 Package mem_pkg SHALL hold the drain-state enum (IDLE, BUSY), the store-entry struct {index, data}, and the default SB_DEPTH and WR_LAT values.
REQ-032 The FIFO with per-entry match logic SHALL be the single sub-module store_buffer_fifo; the RAM array and drain FSM SHALL stay in data_memory_unit.

Verification
REQ-033 Store Addr=5, data 0x00ABCD, then load Addr=5 on the next cycle -> ReadData=0x00ABCD from the buffer; RAM[5] updated at enqueue+3 edges (WR_LAT=2); Empty=1 after that.
REQ-034 Stores Addr=7 with 0x000011 and then 0x000022, followed by a load of 7 -> ReadData=0x000022 (youngest match); after drain, RAM[7]=0x000022.
REQ-035 With WR_LAT=4 and 5 back-to-back stores -> Count reaches 4; the 5th sees StallM=1 until the cycle after the first pop, then is accepted; all 5 are in RAM in order.
REQ-036 Addr=0x800003 with ADDR_W=10 -> stored and read at index 3.
REQ-037 Drive rst low on the completion edge of a pending store to Addr=9 -> RAM[9] keeps its old value; Count=0 and Empty=1 on the following cycle.
REQ-038 Hold en=0 with MemWrite=1 -> Count unchanged and StallM=0; existing entries still drain.
